// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan path (display selector and scan reader).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ssd_pkg;

    // One-hot digit-select codes on ssd_ctrl; the display selector drives the same codes.
    localparam logic [1:0] CTRL_DIG_A = 2'b01;
    localparam logic [1:0] CTRL_DIG_B = 2'b10;

    // Capture progress since reset; only S_FULL means both digits are known.
    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_HAVE_A = 2'd1,
        S_HAVE_B = 2'd2,
        S_FULL   = 2'd3
    } ssd_state_e;

    // Which digit was captured most recently, used to detect an A->B frame.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } last_sel_e;

    function automatic logic ctrl_is_legal(input logic [1:0] ctrl);
        return (ctrl == CTRL_DIG_A) || (ctrl == CTRL_DIG_B);
    endfunction

endpackage

// File: rtl/ssd_scan_capture_stable_filter.sv
// Debounce filter: registers a bus every clock and pulses accept once it has held steady.
// Latency: accept_o is high in the cycle after edge k+STABLE_CYCLES-1 for input constant from edge k.
// Backpressure: none; the filter always samples and the accept pulse is never held off.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   in_i       raw bus to be filtered
//   smp_o      registered sample (the value that accept_o refers to)
//   accept_o   one-cycle pulse, at most once per distinct stable value
module stable_filter #(
    parameter int WIDTH         = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] smp_o,
    output logic             accept_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] smp_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept_q, accept_d;
    logic             same;

    // The incoming value is compared with the sample already held, so the count
    // reflects how many consecutive samples have matched the current one.
    always_comb begin
        same     = (in_i == smp_q);
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Fire only on the STABLE_CYCLES-2 -> STABLE_CYCLES-1 step; saturation
        // above that keeps a steady value from being accepted twice.
        accept_d = same && (cnt_q == CW'(STABLE_CYCLES - 2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q    <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
        end else begin
            smp_q    <= in_i;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
        end
    end

    assign smp_o    = smp_q;
    assign accept_o = accept_q;

endmodule

// File: rtl/ssd_scan_capture.sv
// Scan reader: rebuilds both multiplexed seven-segment digit values from bus + digit select.
// Latency: inputs constant from edge k update the digit/flag outputs at edge k+STABLE_CYCLES.
// Backpressure: none; captures are free-running and outputs are plain registers.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   bus_in            multiplexed digit value
//   ssd_ctrl          digit select (01 = A, 10 = B, others illegal)
//   digit_a, digit_b  last accepted value of each digit
//   valid             both digits captured since reset
//   frame_tick        one-cycle pulse when a B capture directly follows an A capture
//   frame_cnt         count of frame_tick pulses, wraps silently
//   err               one-cycle pulse when a stable illegal select is accepted
module ssd_scan_capture
    import ssd_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   bus_in,
    input  logic [1:0]         ssd_ctrl,
    output logic [WIDTH-1:0]   digit_a,
    output logic [WIDTH-1:0]   digit_b,
    output logic               valid,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               err
);

    logic [WIDTH+1:0] smp;
    logic             accept;
    logic [1:0]       smp_ctrl;
    logic [WIDTH-1:0] smp_bus;

    stable_filter #(
        .WIDTH         (WIDTH + 2),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .in_i     ({ssd_ctrl, bus_in}),
        .smp_o    (smp),
        .accept_o (accept)
    );

    assign smp_ctrl = smp[WIDTH+1:WIDTH];
    assign smp_bus  = smp[WIDTH-1:0];

    logic cap_a, cap_b, cap_bad;

    assign cap_a   = accept && (smp_ctrl == CTRL_DIG_A);
    assign cap_b   = accept && (smp_ctrl == CTRL_DIG_B);
    assign cap_bad = accept && !ctrl_is_legal(smp_ctrl);

    // ---------------- capture datapath ----------------
    logic [WIDTH-1:0]   digit_a_q, digit_a_d;
    logic [WIDTH-1:0]   digit_b_q, digit_b_d;
    last_sel_e          last_sel_q, last_sel_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               frame_tick_q, frame_tick_d;
    logic               err_q, err_d;

    always_comb begin
        digit_a_d    = digit_a_q;
        digit_b_d    = digit_b_q;
        last_sel_d   = last_sel_q;
        frame_cnt_d  = frame_cnt_q;
        frame_tick_d = 1'b0;
        err_d        = cap_bad;
        if (cap_a) begin
            digit_a_d  = smp_bus;
            last_sel_d = SEL_A;
        end else if (cap_b) begin
            digit_b_d  = smp_bus;
            last_sel_d = SEL_B;
            // Only an A immediately followed by a B closes a frame; B-B or a
            // B after reset does not.
            if (last_sel_q == SEL_A) begin
                frame_tick_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_a_q    <= '0;
            digit_b_q    <= '0;
            last_sel_q   <= SEL_NONE;
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            digit_a_q    <= digit_a_d;
            digit_b_q    <= digit_b_d;
            last_sel_q   <= last_sel_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
            err_q        <= err_d;
        end
    end

    // ---------------- fill-state FSM ----------------
    ssd_state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (cap_a)      state_d = S_HAVE_A;
                else if (cap_b) state_d = S_HAVE_B;
            end
            S_HAVE_A: if (cap_b) state_d = S_FULL;
            S_HAVE_B: if (cap_a) state_d = S_FULL;
            S_FULL:   state_d = S_FULL;
            default:  state_d = S_EMPTY;
        endcase
    end

    assign digit_a    = digit_a_q;
    assign digit_b    = digit_b_q;
    assign valid      = (state_q == S_FULL);
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Directed self-checking bench for ssd_scan_capture (default parameters).
// Latency: n/a.
// Backpressure: n/a.
module tb_ssd_scan_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bus_in = 4'h0;
    logic [1:0] ssd_ctrl = 2'b00;
    logic [3:0] digit_a, digit_b;
    logic       valid, frame_tick, err;
    logic [7:0] frame_cnt;

    int total = 0;
    int bad = 0;
    int ticks_seen = 0;
    int errs_seen = 0;
    int overlaps = 0;

    ssd_scan_capture #(
        .WIDTH         (4),
        .STABLE_CYCLES (4),
        .FRAME_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .ssd_ctrl   (ssd_ctrl),
        .digit_a    (digit_a),
        .digit_b    (digit_b),
        .valid      (valid),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (frame_tick) ticks_seen++;
        if (err) errs_seen++;
        if (frame_tick && err) overlaps++;
    endtask

    task automatic run(input logic [1:0] c, input logic [3:0] b, input int n);
        ssd_ctrl = c;
        bus_in   = b;
        repeat (n) step();
    endtask

    initial begin
        // ---- reset state ----
        repeat (2) step();
        check("rst_state", {20'd0, digit_a, digit_b, frame_cnt, valid, frame_tick, err, 1'b0},
              32'd0);

        // ---- idle 0/00 after reset: exactly one err ----
        rst = 1'b0;
        errs_seen = 0;
        run(2'b00, 4'h0, 8);
        check("idle_err", 32'(errs_seen), 32'd1);

        // ---- capture A=7, latency k+4 ----
        ssd_ctrl = 2'b01;
        bus_in   = 4'h7;
        repeat (3) step();
        check("a_k2", 32'(digit_a), 32'h0);
        step();
        check("a_k3", 32'(digit_a), 32'h0);
        step();
        check("a_k4", 32'(digit_a), 32'h7);
        check("a_valid", 32'(valid), 32'd0);
        step();

        // ---- capture B=3 closes a frame ----
        ssd_ctrl = 2'b10;
        bus_in   = 4'h3;
        repeat (4) step();
        check("b_k3_tick", 32'(frame_tick), 32'd0);
        step();
        check("b_k4", 32'(digit_b), 32'h3);
        check("b_valid", 32'(valid), 32'd1);
        check("b_tick", 32'(frame_tick), 32'd1);
        check("b_cnt", 32'(frame_cnt), 32'd1);
        step();
        check("tick_pulse", 32'(frame_tick), 32'd0);

        // ---- glitch: 5 held 3 clk never captured, 9 captured 4 edges later ----
        run(2'b01, 4'h5, 3);
        check("glitch_hold", 32'(digit_a), 32'h7);
        bus_in = 4'h9;
        repeat (3) step();
        check("glitch_k2", 32'(digit_a), 32'h7);
        step();
        check("glitch_k3", 32'(digit_a), 32'h7);
        step();
        check("glitch_k4", 32'(digit_a), 32'h9);
        step();

        // ---- illegal select ----
        errs_seen = 0;
        run(2'b11, 4'h9, 8);
        check("ill_err", 32'(errs_seen), 32'd1);
        check("ill_a", 32'(digit_a), 32'h9);
        check("ill_b", 32'(digit_b), 32'h3);
        check("ill_valid", 32'(valid), 32'd1);
        check("ill_cnt", 32'(frame_cnt), 32'd1);

        // ---- A,A,B -> one tick ----
        ticks_seen = 0;
        run(2'b01, 4'h1, 6);
        run(2'b01, 4'h2, 6);
        check("aab_a", 32'(digit_a), 32'h2);
        run(2'b10, 4'h4, 6);
        check("aab_ticks", 32'(ticks_seen), 32'd1);
        check("aab_cnt", 32'(frame_cnt), 32'd2);

        // ---- async reset mid-run ----
        #2;
        rst = 1'b1;
        #1;
        check("arst_out", {20'd0, digit_a, digit_b, frame_cnt, valid, frame_tick, err, 1'b0},
              32'd0);
        ssd_ctrl = 2'b00;
        bus_in   = 4'h0;
        #1;
        rst = 1'b0;
        errs_seen = 0;
        run(2'b00, 4'h0, 8);
        check("arst_idle_err", 32'(errs_seen), 32'd1);

        // ---- B then A: valid, no tick ----
        ticks_seen = 0;
        run(2'b10, 4'h5, 6);
        check("ba_valid0", 32'(valid), 32'd0);
        run(2'b01, 4'h6, 6);
        check("ba_valid1", 32'(valid), 32'd1);
        check("ba_ticks", 32'(ticks_seen), 32'd0);
        check("ba_digits", {24'd0, digit_a, digit_b}, 32'h65);

        // ---- 256 frames wrap the counter ----
        ticks_seen = 0;
        for (int i = 0; i < 256; i++) begin
            run(2'b10, 4'(i), 5);
            if (i == 254) check("wrap_255", 32'(frame_cnt), 32'd255);
            run(2'b01, 4'(i + 3), 5);
        end
        check("wrap_ticks", 32'(ticks_seen), 32'd256);
        check("wrap_cnt", 32'(frame_cnt), 32'd0);

        // ---- reset at stability count 2 forces a full re-count ----
        rst      = 1'b1;
        ssd_ctrl = 2'b00;
        bus_in   = 4'h0;
        #2;
        rst = 1'b0;
        run(2'b00, 4'h0, 6);
        ssd_ctrl = 2'b01;
        bus_in   = 4'hC;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
        check("rms_k0", 32'(digit_a), 32'h0);
        repeat (3) step();
        check("rms_k3", 32'(digit_a), 32'h0);
        step();
        check("rms_k4", 32'(digit_a), 32'hC);

        check("tick_err_overlap", 32'(overlaps), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
